// File: rtl/branch_predictor_bht.sv
// ---------------------------------------------------------------------------
// branch_predictor_bht
//   Branch history table of 2-bit saturating counters indexed by PC[IDX_W+1:2].
//   Gives a zero-latency taken prediction to fetch, trains from the resolved
//   execute-stage outcome, runs a multi-cycle table clear, and keeps
//   saturating branch / mispredict counters.
//
// Ports
//   clk, rst_n           core clock, async active-low reset
//   lkp_vld, lkp_pc      lookup request from fetch
//   br_pred              predicted taken (combinational from table state)
//   upd_vld, upd_pc      resolved conditional branch from execute
//   upd_taken, upd_flush actual outcome / mispredict flag
//   clr_req              one-cycle pulse requesting a full table clear
//   clr_busy             clear sweep in progress
//   br_cnt, mis_cnt      resolved-branch and mispredict counters
// ---------------------------------------------------------------------------
module branch_predictor_bht #(
    parameter int IDX_W = 6,
    parameter int PC_W  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lkp_vld,
    input  logic [PC_W-1:0]  lkp_pc,
    output logic             br_pred,
    input  logic             upd_vld,
    input  logic [PC_W-1:0]  upd_pc,
    input  logic             upd_taken,
    input  logic             upd_flush,
    input  logic             clr_req,
    output logic             clr_busy,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] mis_cnt
);

    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t           state, state_nxt;
    logic [IDX_W:0]   clr_ptr, clr_ptr_nxt;   // MSB set = sweep finished
    logic [1:0]       tbl [DEPTH];

    logic [IDX_W-1:0] lkp_idx, upd_idx;
    logic [1:0]       upd_cur, upd_nxt;
    logic             upd_en;

    // Only the word-index bits of the PCs select an entry.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lkp_pc[PC_W-1:IDX_W+2], lkp_pc[1:0],
                              upd_pc[PC_W-1:IDX_W+2], upd_pc[1:0]};

    assign lkp_idx  = lkp_pc[IDX_W+1:2];
    assign upd_idx  = upd_pc[IDX_W+1:2];
    assign clr_busy = (state == CLEAR);

    // No forwarding: a same-cycle update to the looked-up entry is not seen.
    assign br_pred = lkp_vld & ~clr_busy & tbl[lkp_idx][1];

    // A clear request in the same IDLE cycle wins over the table update.
    assign upd_en  = upd_vld & (state == IDLE) & ~clr_req;
    assign upd_cur = tbl[upd_idx];

    always_comb begin
        upd_nxt = upd_cur;
        if (upd_taken) begin
            if (upd_cur != 2'b11) upd_nxt = upd_cur + 2'd1;
        end else begin
            if (upd_cur != 2'b00) upd_nxt = upd_cur - 2'd1;
        end
    end

    // Clear FSM: next state / pointer
    always_comb begin
        state_nxt   = state;
        clr_ptr_nxt = clr_ptr;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt   = CLEAR;
                    clr_ptr_nxt = '0;
                end
            end
            CLEAR: begin
                clr_ptr_nxt = clr_ptr + 1'b1;
                // Leave once the last entry is being written this cycle.
                if (clr_ptr_nxt[IDX_W]) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            clr_ptr <= '0;
        end else begin
            state   <= state_nxt;
            clr_ptr <= clr_ptr_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) tbl[i] <= 2'b01;
        end else if (state == CLEAR) begin
            tbl[clr_ptr[IDX_W-1:0]] <= 2'b01;
        end else if (upd_en) begin
            tbl[upd_idx] <= upd_nxt;
        end
    end

    // Counters run regardless of clear state and stick at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt  <= '0;
            mis_cnt <= '0;
        end else begin
            if (upd_vld && !(&br_cnt))
                br_cnt <= br_cnt + CNT_W'(1);
            if (upd_vld && upd_flush && !(&mis_cnt))
                mis_cnt <= mis_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/branch_predictor_bht.md
Name: branch_predictor_bht

Overview:
- Branch history table (BHT) of 2-bit saturating counters, indexed by PC.
- Supplies `br_pred` to the fetch/decode path for conditional branches.
- Trains from the execute stage's resolved outcome (actual taken and flush) on every resolved branch.
- Also sequences a multi-cycle table clear and keeps branch/mispredict performance counters.

Parameters:
- IDX_W, 6, BHT index width; table depth = 2^IDX_W entries.
- PC_W, 32, PC width.
- CNT_W, 32, performance counter width.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- lkp_vld  in  1  lookup request from fetch this cycle
- lkp_pc  in  PC_W  PC of instruction being looked up
- br_pred  out  1  predicted taken; combinational from lookup
- upd_vld  in  1  execute stage resolved a conditional branch this cycle
- upd_pc  in  PC_W  PC of the resolved branch
- upd_taken  in  1  actual branch outcome
- upd_flush  in  1  resolved branch was mispredicted (flush asserted)
- clr_req  in  1  single-cycle pulse: clear whole table
- clr_busy  out  1  clear sequence in progress
- br_cnt  out  CNT_W  resolved branch count
- mis_cnt  out  CNT_W  mispredict count

Behaviour:
- Index: `idx = pc[IDX_W+1:2]` for both lookup and update.
- Counter encoding:
  - 00 strong-not-taken, 01 weak-not-taken, 10 weak-taken, 11 strong-taken.
  - Prediction = counter MSB.
- Reset (async, `rst_n` low):
  - every entry = 01.
  - `clr_busy` = 0, FSM = IDLE.
  - `br_cnt` = 0, `mis_cnt` = 0.
  - `br_pred` = 0 (table MSBs are all 0).
- `br_pred = lkp_vld & ~clr_busy & tbl[idx(lkp_pc)][1]`. Zero latency, purely combinational from registered table state.
- Update, applied at clk rising edge when `upd_vld` and FSM = IDLE:
  - `upd_taken` = 1: counter increments, saturating at 11.
  - `upd_taken` = 0: counter decrements, saturating at 00.
- Lookup and update to the same index in the same cycle: lookup returns the pre-update value. There is no forwarding.
- Performance counters:
  - On `upd_vld`: `br_cnt` += 1.
  - On `upd_vld & upd_flush`: `mis_cnt` += 1.
  - Both saturate at all-ones and never wrap.
  - Both count regardless of FSM state.
  - `upd_flush` without `upd_vld` is ignored.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR on `clr_req`. The internal pointer `clr_ptr` loads 0.
  - CLEAR: each cycle writes entry `clr_ptr` = 01 and increments `clr_ptr`.
  - CLEAR -> IDLE in the cycle after entry 2^IDX_W-1 is written. The full clear is exactly 2^IDX_W cycles.
  - `clr_busy` = 1 exactly while in CLEAR. It is registered: it goes high the cycle after `clr_req`.
  - During CLEAR, `upd_vld` table updates are dropped. The counters still count.
  - `clr_req` while in CLEAR is ignored; the sweep does not restart.
- `clr_req` and `upd_vld` in the same IDLE cycle: the update to the table is dropped and the clear starts.
- Reset mid-clear: the FSM returns to IDLE and all entries become 01 immediately.
- Widths: `clr_ptr` is IDX_W+1 bits. Its MSB set marks completion. Pointer wrap-around must never alias entry 0.

Test Plan:
- Reset, then lookup any PC with `lkp_vld`=1 -> `br_pred`=0; `br_cnt`=`mis_cnt`=0; `clr_busy`=0.
- Train PC 0x0000_0040 taken twice (`upd_vld`, `upd_taken`=1) -> after 1st update, lookup 0x40 gives `br_pred`=1 (10). After 2nd, 11. A third taken stays 11. One not-taken gives 10, `br_pred` still 1.
- Aliasing: train PC 0x40 to 11, then look up PC 0x140 (IDX_W=6, same idx 16) -> `br_pred`=1. Look up PC 0x44 -> `br_pred`=0.
- Same-cycle lookup+update on PC 0x80 at 01 with `upd_taken`=1 -> that cycle `br_pred`=0. Next cycle lookup -> 1.
- Clear: train 5 entries to 11, pulse `clr_req` -> `clr_busy` high for exactly 64 cycles. `br_pred`=0 throughout. An update issued mid-clear does not modify the table, but `br_cnt` increments. Afterwards, all 5 PCs predict 0.
- Counters: issue 10 updates, 3 with `upd_flush`=1 -> `br_cnt`=10, `mis_cnt`=3. With CNT_W forced to 4, issue 20 updates -> `br_cnt` holds 15. Assert `rst_n`=0 mid-clear -> `clr_busy`=0 asynchronously and counters=0.
